// File: rtl/wb_port_arbiter_pkg.sv
// wb_port_arbiter_pkg: shared widths, default sizing and the {rd, data} writeback request layout
package wb_port_arbiter_pkg;
  localparam int XLEN = 32;
  localparam int REGW = 5;
  localparam int DEF_DEPTH = 2;
  localparam int DEF_STARVE_MAX = 4;
  typedef struct packed {
    logic [REGW-1:0] rd;
    logic [XLEN-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/wb_port_arbiter_ret_fifo.sv
// wb_ret_fifo: DEPTH-entry circular buffer of load returns (push/pop in, head/full/empty and per-entry valid+rd out for hazard compares)
module wb_ret_fifo
  import wb_port_arbiter_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  wb_req_t         push_req,
  input  logic            pop,
  output wb_req_t         head,
  output logic            full,
  output logic            empty,
  output logic [DEPTH-1:0] ent_vld,
  output logic [REGW-1:0] ent_rd [DEPTH]
);
  localparam int AW = $clog2(DEPTH);
  wb_req_t mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem[wp] <= push_req;
  assign head  = mem[rp];
  assign full  = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    logic [AW-1:0] off;
    assign off        = AW'(i) - rp;
    assign ent_vld[i] = {1'b0, off} < cnt;
    assign ent_rd[i]  = mem[i].rd;
  end
endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: one-write-per-cycle register-file port shared by the execute path and a buffered load-return path
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int DEPTH      = DEF_DEPTH,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  input  logic [REGW-1:0] ex_rd,
  input  logic [XLEN-1:0] ex_data,
  output logic            ex_ready,
  input  logic            ld_valid,
  input  logic [REGW-1:0] ld_rd,
  input  logic [XLEN-1:0] ld_data,
  output logic            ld_ready,
  input  logic [REGW-1:0] chk_rs1,
  input  logic [REGW-1:0] chk_rs2,
  output logic            pend_hit1,
  output logic            pend_hit2,
  output logic            rf_we,
  output logic [REGW-1:0] rf_waddr,
  output logic [XLEN-1:0] rf_wdata
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic full, empty, push, pop, waw, force_ld, gnt_ex;
  logic [DEPTH-1:0] ent_vld, ex_hit, hit1, hit2;
  logic [REGW-1:0] ent_rd [DEPTH];
  logic [SW-1:0] starve;
  wb_req_t head, win;
  wb_ret_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(push), .push_req({ld_rd, ld_data}), .pop(pop),
    .head(head), .full(full), .empty(empty), .ent_vld(ent_vld), .ent_rd(ent_rd)
  );
  for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
    assign ex_hit[i] = ent_vld[i] && ent_rd[i] == ex_rd;
    assign hit1[i]   = ent_vld[i] && ent_rd[i] == chk_rs1;
    assign hit2[i]   = ent_vld[i] && ent_rd[i] == chk_rs2;
  end
  always_comb begin
    ld_ready  = !full;
    push      = ld_valid && !full;
    waw       = ex_valid && ex_rd != '0 && |ex_hit;
    force_ld  = !empty && (starve == SW'(STARVE_MAX) || full || waw);
    gnt_ex    = ex_valid && !force_ld;
    pop       = !empty && !gnt_ex;
    ex_ready  = gnt_ex;
    win       = gnt_ex ? wb_req_t'({ex_rd, ex_data}) : head;
    pend_hit1 = chk_rs1 != '0 && |hit1;
    pend_hit2 = chk_rs2 != '0 && |hit2;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) starve <= '0;
    else if (empty || pop) starve <= '0;
    else if (gnt_ex && starve != SW'(STARVE_MAX)) starve <= starve + 1'b1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= (gnt_ex || pop) && win.rd != '0;
      if (gnt_ex || pop) begin
        rf_waddr <= win.rd;
        rf_wdata <= win.data;
      end
    end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed vectors against hand-computed writeback results
module tb_wb_port_arbiter;
  import wb_port_arbiter_pkg::*;
  logic clk = 0, rst_n = 0;
  logic ex_valid = 0, ld_valid = 0, ex_ready, ld_ready, pend_hit1, pend_hit2, rf_we;
  logic [REGW-1:0] ex_rd = 0, ld_rd = 0, chk_rs1 = 0, chk_rs2 = 0, rf_waddr;
  logic [XLEN-1:0] ex_data = 0, ld_data = 0, rf_wdata;
  int n_chk = 0, n_pass = 0;
  wb_port_arbiter dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_data(ex_data),
    .ex_ready(ex_ready), .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data),
    .ld_ready(ld_ready), .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .pend_hit1(pend_hit1),
    .pend_hit2(pend_hit2), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  initial begin
    tick();
    tick();
    chk("rst_we", rf_we, 0);
    chk("rst_waddr", rf_waddr, 0);
    chk("rst_wdata", rf_wdata, 0);
    rst_n = 1;
    tick();
    chk("rst_ld_ready", ld_ready, 1);
    chk("rst_ex_ready_idle", ex_ready, 0);
    ld_valid = 1; ld_rd = 5; ld_data = 32'hDEADBEEF; chk_rs1 = 5;
    tick();
    ld_valid = 0;
    chk("lone_lat1_we", rf_we, 0);
    chk("lone_pend", pend_hit1, 1);
    tick();
    chk("lone_we", rf_we, 1);
    chk("lone_waddr", rf_waddr, 5);
    chk("lone_wdata", rf_wdata, 32'hDEADBEEF);
    chk("lone_pend_clr", pend_hit1, 0);
    tick();
    chk("idle_we", rf_we, 0);
    chk("idle_hold_addr", rf_waddr, 5);
    ld_valid = 1; ld_rd = 9; ld_data = 32'h11;
    tick();
    ld_valid = 0; ex_valid = 1; ex_rd = 9; ex_data = 32'h22;
    #1 chk("waw_ex_blocked", ex_ready, 0);
    tick();
    chk("waw_first_addr", rf_waddr, 9);
    chk("waw_first_data", rf_wdata, 32'h11);
    chk("waw_ex_ready", ex_ready, 1);
    tick();
    ex_valid = 0;
    chk("waw_second_data", rf_wdata, 32'h22);
    chk("waw_second_we", rf_we, 1);
    ld_valid = 1; ld_rd = 7; ld_data = 32'h77;
    tick();
    ld_valid = 0; ex_valid = 1;
    for (int k = 0; k < 4; k++) begin
      ex_rd = REGW'(10 + k); ex_data = XLEN'(k);
      #1 chk("starve_ex_ready", ex_ready, 1);
      tick();
      chk("starve_ex_addr", rf_waddr, 10 + k);
    end
    ex_rd = 14; ex_data = 32'h14;
    #1 chk("starve_ex_held", ex_ready, 0);
    tick();
    chk("starve_ld_addr", rf_waddr, 7);
    chk("starve_ld_data", rf_wdata, 32'h77);
    chk("starve_ex_back", ex_ready, 1);
    tick();
    ex_valid = 0;
    chk("starve_ex_last", rf_waddr, 14);
    ex_valid = 1; ex_rd = 20; ex_data = 32'h20; ld_valid = 1; ld_rd = 3; ld_data = 32'h33;
    #1 chk("full_a_ex_ready", ex_ready, 1);
    tick();
    ex_rd = 21; ex_data = 32'h21; ld_rd = 4; ld_data = 32'h44;
    tick();
    chk("full_b_addr", rf_waddr, 21);
    ex_rd = 22; ex_data = 32'h22; ld_rd = 6; ld_data = 32'h66; chk_rs2 = 4;
    #1 chk("full_ld_ready", ld_ready, 0);
    chk("full_ex_ready", ex_ready, 0);
    chk("full_pend2", pend_hit2, 1);
    tick();
    chk("full_head_addr", rf_waddr, 3);
    chk("full_head_we", rf_we, 1);
    chk("full_ld_ready_back", ld_ready, 1);
    ex_valid = 0;
    tick();
    ld_valid = 0;
    chk("full_d_addr", rf_waddr, 4);
    tick();
    chk("full_e_addr", rf_waddr, 6);
    chk("full_e_data", rf_wdata, 32'h66);
    chk("full_pend2_clr", pend_hit2, 0);
    chk_rs1 = 0; chk_rs2 = 0;
    ex_valid = 1; ex_rd = 0; ex_data = 32'h55; ld_valid = 1; ld_rd = 0; ld_data = 32'h66;
    #1 chk("x0_ex_ready", ex_ready, 1);
    chk("x0_ld_ready", ld_ready, 1);
    tick();
    ex_valid = 0; ld_valid = 0;
    chk("x0_ex_we", rf_we, 0);
    chk("x0_ex_waddr", rf_waddr, 0);
    #1 chk("x0_pend1", pend_hit1, 0);
    tick();
    chk("x0_ld_we", rf_we, 0);
    tick();
    chk("x0_drained_we", rf_we, 0);
    ex_valid = 1; ex_rd = 25; ex_data = 32'h25; ld_valid = 1; ld_rd = 8; ld_data = 32'h88;
    tick();
    ex_rd = 26; ex_data = 32'h26; ld_rd = 9; ld_data = 32'h99;
    tick();
    ex_valid = 0; ld_valid = 0; chk_rs1 = 8; chk_rs2 = 9;
    #1 chk("mid_pend1", pend_hit1, 1);
    chk("mid_pend2", pend_hit2, 1);
    chk("mid_we_before", rf_we, 1);
    rst_n = 0;
    #1 chk("mid_rst_we", rf_we, 0);
    chk("mid_rst_pend1", pend_hit1, 0);
    chk("mid_rst_pend2", pend_hit2, 0);
    tick();
    rst_n = 1;
    #1 chk("mid_ld_ready", ld_ready, 1);
    tick();
    chk("mid_no_stale1", rf_we, 0);
    tick();
    chk("mid_no_stale2", rf_we, 0);
    chk("mid_waddr", rf_waddr, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
